// File: rtl/led_cube_uart_rx.sv
// 8N1 UART receiver for the LED cube: two-flop synchronised rx, mid-bit sampling,
// single-cycle readdatavalid / framing_error pulses, break-tolerant recovery.
module led_cube_uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] uart_in,
    output logic       readdatavalid,
    output logic       framing_error,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shreg, shreg_d;
    logic [7:0]    uart_d;
    logic          rdv_d, fe_d;
    logic [1:0]    sync_q;
    logic          rx_s;

    assign rx_s = sync_q[1];
    assign busy = (state != IDLE);

    // NOTE: every register here uses <= so all flops update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= 2'b11;
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            uart_in       <= '0;
            readdatavalid <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], rx};
            state         <= state_d;
            cnt           <= cnt_d;
            idx           <= idx_d;
            shreg         <= shreg_d;
            uart_in       <= uart_d;
            readdatavalid <= rdv_d;
            framing_error <= fe_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        idx_d   = idx;
        shreg_d = shreg;
        uart_d  = uart_in;
        rdv_d   = 1'b0;
        fe_d    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                // Half a bit in: a line that is already high again was only a glitch.
                if (cnt == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_d        = '0;
                    shreg_d[idx] = rx_s;
                    idx_d        = idx + 3'd1;
                    if (idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                        uart_d  = shreg;
                        rdv_d   = 1'b1;
                    end else begin
                        state_d = WAIT_HIGH;
                        fe_d    = 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_led_cube_uart_rx.sv
// Randomised self-checking bench for led_cube_uart_rx: the bench knows every frame it
// sends and predicts the resulting pulses, their data and their timing.
module tb_led_cube_uart_rx;

    localparam int CPB     = 16;
    localparam int LAT     = 9 * CPB + CPB / 2 + 3;  // stop-bit middle plus sync and output register

    typedef struct {
        logic       is_fe;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] uart_in;
    logic       readdatavalid;
    logic       framing_error;
    logic       busy;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_start = 0;
    logic prev_pulse = 1'b0;
    logic [7:0] model_last = 8'h00;
    ev_t  exp_q[$];
    int   rdv_cyc[$];

    led_cube_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .uart_in       (uart_in),
        .readdatavalid (readdatavalid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Every pulse is matched against the oldest predicted event.
    always @(negedge clk) begin
        if (!rst && (readdatavalid || framing_error)) begin
            ev_t e;
            check("pulse_exclusive", 32'(readdatavalid & framing_error), 0);
            check("pulse_single", 32'(prev_pulse), 0);
            if (readdatavalid) rdv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {readdatavalid, framing_error}, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_fe", 32'(framing_error), 32'(e.is_fe));
                check("pulse_latency", cyc - last_start, LAT);
                if (e.is_fe) begin
                    check("uart_in_kept", uart_in, model_last);
                end else begin
                    check("uart_in_data", uart_in, e.data);
                    model_last = e.data;
                end
            end
        end
        prev_pulse = !rst && (readdatavalid || framing_error);
    end

    // All drive tasks start and end at posedge+1.
    task automatic hold(input logic v, input int n);
        rx = v;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int gap);
        ev_t e;
        e.is_fe = !stop_ok;
        e.data  = b;
        exp_q.push_back(e);
        last_start = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_ok, CPB);
        hold(1'b1, gap);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_in", uart_in, 0);
        check("rst_valid", 32'(readdatavalid), 0);
        check("rst_fe", 32'(framing_error), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        hold(1'b1, 5);

        // Plain good frame, then an idle check.
        send_frame(8'hA5, 1'b1, 10);
        wait_drain("a5_pending");
        check("a5_value", uart_in, 8'hA5);
        check("a5_busy_after", 32'(busy), 0);

        // Short low glitch on the line must be ignored.
        hold(1'b0, 4);
        hold(1'b1, 20);
        check("glitch_busy", 32'(busy), 0);
        check("glitch_uart_in", uart_in, 8'hA5);

        // Bad stop bit, then recovery with a good frame.
        send_frame(8'h3C, 1'b0, 6);
        wait_drain("fe_pending");
        check("fe_uart_in", uart_in, 8'hA5);
        check("fe_busy_after", 32'(busy), 0);
        send_frame(8'h5A, 1'b1, 10);
        wait_drain("5a_pending");
        check("5a_value", uart_in, 8'h5A);

        // Back-to-back frames without an idle gap.
        rdv_cyc.delete();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 10);
        wait_drain("b2b_pending");
        check("b2b_count", rdv_cyc.size(), 2);
        if (rdv_cyc.size() == 2) check("b2b_spacing", rdv_cyc[1] - rdv_cyc[0], 10 * CPB);
        check("b2b_last", uart_in, 8'hFF);

        // Reset in the middle of data bit 4 aborts the frame silently.
        begin
            logic [7:0] ab = 8'h5A;
            hold(1'b0, CPB);
            for (int i = 0; i < 4; i++) hold(ab[i], CPB);
            hold(ab[4], CPB / 2);
        end
        rst = 1'b1;
        rx  = 1'b1;
        model_last = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_uart_in", uart_in, 0);
        check("midrst_valid", 32'(readdatavalid), 0);
        check("midrst_fe", 32'(framing_error), 0);
        check("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        hold(1'b1, 40);
        check("postrst_uart_in", uart_in, 0);
        send_frame(8'h81, 1'b1, 10);
        wait_drain("81_pending");
        check("81_value", uart_in, 8'h81);

        // Break: line held low for a long time gives exactly one framing error.
        begin
            ev_t e;
            e.is_fe = 1'b1;
            e.data  = 8'h00;
            exp_q.push_back(e);
            last_start = cyc;
            hold(1'b0, 500);
            hold(1'b1, 30);
        end
        wait_drain("break_pending");
        check("break_busy", 32'(busy), 0);
        check("break_uart_in", uart_in, 8'h81);

        // Random traffic: good frames, bad stops, glitches, random gaps.
        for (int n = 0; n < 40; n++) begin
            int unsigned r = $urandom_range(0, 99);
            if (r < 15) begin
                hold(1'b0, $urandom_range(1, CPB / 2 - 2));
                hold(1'b1, 12);
                check("rand_glitch_uart_in", uart_in, model_last);
            end else if (r < 35) begin
                send_frame(8'($urandom), 1'b0, $urandom_range(4, 8));
            end else begin
                send_frame(8'($urandom), 1'b1, $urandom_range(0, 5));
            end
        end
        hold(1'b1, 20);
        wait_drain("rand_pending");
        check("rand_final_uart_in", uart_in, model_last);
        check("rand_final_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_cube_uart_rx.md
LED_CUBE_UART_RX -- requirements
Module: led_cube_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, sets clk cycles per UART bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 uart_in  output  8  last correctly received byte; feeds driver/config byte input.
REQ-006 readdatavalid  output  1  single-cycle pulse, high the cycle uart_in first presents a new byte.
REQ-007 framing_error  output  1  single-cycle pulse on a bad stop bit.
REQ-008 busy  output  1  high whenever state is not IDLE.

Function
REQ-009 rx shall pass through a two-flop synchronizer; all decisions shall use the synchronized value rx_s; synchronizer flops reset to 1.
REQ-010 States shall be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-011 A bit counter, 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT), shall clear on every state entry and on each bit boundary.
REQ-012 IDLE: on rx_s==0, go to START and clear the counter.
REQ-013 START: when counter reaches (CLKS_PER_BIT/2)-1, integer division, sample rx_s (mid-start-bit).
REQ-014 START sample of 1 is a glitch: go to IDLE; no pulse; uart_in unchanged.
REQ-015 START sample of 0: go to DATA with bit index 0 and counter cleared.
REQ-016 DATA: each time counter reaches CLKS_PER_BIT-1, shift rx_s into bit [index] of a shift register (LSB first) and increment index (3-bit).
REQ-017 DATA: after the sample at index 7, go to STOP.
REQ-018 STOP: when counter reaches CLKS_PER_BIT-1, sample rx_s.
REQ-019 STOP sample of 1: on the next edge, load uart_in with the shift register, pulse readdatavalid for exactly one cycle, and go to IDLE.
REQ-020 STOP sample of 0: on the next edge, pulse framing_error for one cycle, leave uart_in unchanged, and go to WAIT_HIGH.
REQ-021 WAIT_HIGH: stay until rx_s==1, then go to IDLE; a held-low (break) line shall yield exactly one framing_error.
REQ-022 readdatavalid and framing_error shall never be high in the same cycle; neither shall be high for two consecutive cycles.
REQ-023 Back-to-back frames (next start bit right after the stop bit) shall be received without loss; IDLE shall accept a start the cycle after the STOP decision.
REQ-024 uart_in shall hold its value between valid pulses.
REQ-025 Latency: readdatavalid shall assert 3 cycles (2 synchronizer stages plus 1 register) after the stop-bit mid-sample point on raw rx.
REQ-026 No parity, no FIFO, no backpressure; a consumer that misses a pulse loses the byte.

Reset
REQ-027 While rst is high at a clock edge: state=IDLE; counter, index, shift register, uart_in=0; readdatavalid=0; framing_error=0; busy=0; synchronizer=1.
REQ-028 rst mid-frame shall abort the frame with no pulse; the first full frame starting after rst deasserts shall be received correctly.

Verification (CLKS_PER_BIT=16)
REQ-029 Frame 0xA5 with stop=1 -> uart_in=0xA5, readdatavalid high exactly 1 cycle, framing_error never high, busy low afterwards.
REQ-030 rx low for 4 cycles then high -> back to IDLE via glitch path; no pulses; uart_in unchanged.
REQ-031 0x3C sent with stop=0 -> one framing_error pulse, uart_in keeps previous 0xA5; rx then high -> IDLE; next frame 0x5A -> uart_in=0x5A.
REQ-032 Back-to-back 0x00 then 0xFF, no idle gap -> two readdatavalid pulses 160 cycles apart, values 0x00 then 0xFF.
REQ-033 rst pulsed during DATA bit 4 -> all outputs 0, no pulse; following 0x81 frame -> uart_in=0x81 with one readdatavalid.
REQ-034 rx held low 500 cycles then released -> exactly one framing_error; no readdatavalid; IDLE after release.
